// File: rtl/sm_add_arbiter.sv
// Two-requester round-robin front end for a single shared sign-magnitude adder.
// A one-entry output buffer holds the result for its owner; throughput is one result per cycle.
module sm_add_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_sat,
  output logic [7:0]       sat_count
);

  localparam int MAG = WIDTH - 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic [7:0]       cnt_q, cnt_d;

  logic grant;
  logic any_valid;
  logic owner_ready;
  logic can_accept;
  logic consumed;
  logic accept;

  // With both requesters waiting, the one not served last wins.
  assign any_valid   = req0_valid | req1_valid;
  assign grant       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;
  assign consumed    = (state_q == FULL) & owner_ready;
  assign can_accept  = (state_q == EMPTY) | consumed;

  assign req0_ready = ~rst & can_accept & any_valid & ~grant;
  assign req1_ready = ~rst & can_accept & any_valid & grant;
  assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

  logic [WIDTH-1:0] op_a, op_b;
  logic             a_sign, b_sign, diff_sign, swap, clamp, res_sign;
  logic [MAG-1:0]   a_mag, b_mag, big_mag, small_mag, addend, res_mag;
  logic [MAG:0]     sum;

  assign op_a   = grant ? req1_a : req0_a;
  assign op_b   = grant ? req1_b : req0_b;
  assign a_sign = op_a[WIDTH-1];
  assign b_sign = op_b[WIDTH-1];
  assign a_mag  = op_a[MAG-1:0];
  assign b_mag  = op_b[MAG-1:0];

  // Single add path: subtraction is big + ~small + 1, so the carry-out is
  // meaningful only for same-sign sums, where it flags overflow.
  assign diff_sign = a_sign ^ b_sign;
  assign swap      = b_mag > a_mag;
  assign big_mag   = swap ? b_mag : a_mag;
  assign small_mag = swap ? a_mag : b_mag;
  assign addend    = diff_sign ? ~small_mag : small_mag;
  assign sum       = {1'b0, big_mag} + {1'b0, addend} + {{MAG{1'b0}}, diff_sign};
  assign clamp     = ~diff_sign & sum[MAG];
  assign res_mag   = clamp ? {MAG{1'b1}} : sum[MAG-1:0];
  assign res_sign  = (a_mag > b_mag) ? a_sign : b_sign;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      owner_d = grant;
      last_d  = grant;
      data_d  = {res_sign, res_mag};
      sat_d   = clamp;
      if (clamp && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (consumed) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp0_valid = (state_q == FULL) & ~owner_q;
  assign rsp1_valid = (state_q == FULL) & owner_q;
  assign rsp_data   = data_q;
  assign rsp_sat    = sat_q;
  assign sat_count  = cnt_q;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Bench for sm_add_arbiter: directed scenarios plus a randomized run against an
// integer-arithmetic reference adder and a transaction-level buffer model.
module tb_sm_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp_data;
  logic        rsp_sat;
  logic [7:0]  sat_count;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit          m_full, m_owner, m_last, m_sat;
  logic [15:0] m_data;
  int          m_cnt;
  int          exp_grant;
  bit          e_rdy0, e_rdy1;

  sm_add_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_sat(rsp_sat), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Returns {sat, result}: exact signed sum, clamped to +/-32767; a zero result takes B's sign.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int va, vb, s;
    bit sat;
    logic [15:0] r;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    s = va + vb;
    sat = 1'b0;
    if (s > 32767) begin s = 32767; sat = 1'b1; end
    if (s < -32767) begin s = -32767; sat = 1'b1; end
    if (s == 0) r = {b[15], 15'h0000};
    else if (s < 0) r = {1'b1, 15'(-s)};
    else r = {1'b0, 15'(s)};
    return {sat, r};
  endfunction

  task automatic reset_model();
    m_full = 0; m_owner = 0; m_last = 1; m_sat = 0; m_data = 16'h0000; m_cnt = 0;
  endtask

  task automatic predict();
    bit can;
    if (req0_valid && req1_valid) exp_grant = m_last ? 0 : 1;
    else exp_grant = req1_valid ? 1 : 0;
    can = !m_full || (m_owner ? rsp1_ready : rsp0_ready);
    e_rdy0 = !rst && can && req0_valid && (exp_grant == 0);
    e_rdy1 = !rst && can && req1_valid && (exp_grant == 1);
  endtask

  // One clock: predicts the accept from current inputs, then updates the model.
  task automatic advance();
    bit acc, cons;
    logic [16:0] r;
    predict();
    acc = e_rdy0 || e_rdy1;
    cons = m_full && (m_owner ? rsp1_ready : rsp0_ready);
    r = (exp_grant == 1) ? ref_add(req1_a, req1_b) : ref_add(req0_a, req0_b);
    @(posedge clk); #1;
    if (acc) begin
      m_full = 1; m_owner = (exp_grant == 1); m_last = (exp_grant == 1);
      m_sat = r[16]; m_data = r[15:0];
      if (r[16] && m_cnt < 255) m_cnt++;
      $display("txn t=%0t grant=%0d result=%h sat=%0d", $time, exp_grant, r[15:0], r[16]);
    end else if (cons) begin
      m_full = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req0_valid = 0; req1_valid = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    reset_model();
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_rdy0 got=%b want=0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_rdy1 got=%b want=0", req1_ready); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp0v got=%b want=0", rsp0_valid); end
    rst = 0; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL idle_rspv got=%b%b want=00", rsp0_valid, rsp1_valid); end
    total++; if (rsp_data !== 16'h0000) begin bad++; $display("FAIL idle_data got=%h want=0000", rsp_data); end
    total++; if (sat_count !== 8'd0) begin bad++; $display("FAIL idle_satcnt got=%0d want=0", sat_count); end
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL idle_rdy got=%b%b want=00", req0_ready, req1_ready); end
  endtask

  task automatic test_basic();
    req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0003; rsp0_ready = 0; rsp1_ready = 0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL basic_rdy0 got=%b want=1", req0_ready); end
    advance();
    req0_valid = 0;
    #1;
    total++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL basic_rspv got=%b%b want=10", rsp0_valid, rsp1_valid); end
    total++; if (rsp_data !== 16'h0008 || rsp_sat !== 1'b0) begin bad++; $display("FAIL basic_data got=%h/%b want=0008/0", rsp_data, rsp_sat); end
    rsp0_ready = 1;
    advance();
    total++; if (rsp0_valid !== 1'b0 || rsp_data !== 16'h0008) begin bad++; $display("FAIL basic_drain got=%b/%h want=0/0008", rsp0_valid, rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] r;
    do_reset();
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 8; i++) begin
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      #1;
      r = (i % 2 == 1) ? ref_add(req1_a, req1_b) : ref_add(req0_a, req0_b);
      total++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin bad++; $display("FAIL b2b_grant i=%0d got=%b%b want_grant=%0d", i, req0_ready, req1_ready, i % 2); end
      advance();
      total++; if (rsp0_valid !== (i % 2 == 0) || rsp1_valid !== (i % 2 == 1) || rsp_data !== r[15:0]) begin bad++; $display("FAIL b2b_rsp i=%0d got=%b%b/%h want_port=%0d/%h", i, rsp0_valid, rsp1_valid, rsp_data, i % 2, r[15:0]); end
    end
    req0_valid = 0; req1_valid = 0;
    advance();
  endtask

  task automatic test_saturation();
    logic [15:0] va[2] = '{16'h7000, 16'hF000};
    logic [15:0] vb[2] = '{16'h1000, 16'h9000};
    logic [15:0] vr[2] = '{16'h7FFF, 16'hFFFF};
    logic [16:0] r;
    int am, bm, sg;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 0; req1_valid = 0; req0_valid = 1;
    for (int i = 0; i < 2; i++) begin
      req0_a = va[i]; req0_b = vb[i];
      advance();
      total++; if (rsp_data !== vr[i] || rsp_sat !== 1'b1) begin bad++; $display("FAIL sat_vec%0d got=%h/%b want=%h/1", i, rsp_data, rsp_sat, vr[i]); end
    end
    total++; if (sat_count !== 8'd2) begin bad++; $display("FAIL sat_count2 got=%0d want=2", sat_count); end
    for (int i = 0; i < 300; i++) begin
      am = $urandom_range(16384, 32767);
      bm = $urandom_range(32768 - am, 32767);
      sg = $urandom_range(0, 1);
      req0_a = {sg[0], 15'(am)}; req0_b = {sg[0], 15'(bm)};
      r = ref_add(req0_a, req0_b);
      advance();
      total++; if (rsp_sat !== 1'b1 || rsp_data !== r[15:0] || sat_count !== 8'(m_cnt)) begin bad++; $display("FAIL sat_loop i=%0d got=%h/%b/%0d want=%h/1/%0d", i, rsp_data, rsp_sat, sat_count, r[15:0], m_cnt); end
    end
    total++; if (sat_count !== 8'd255) begin bad++; $display("FAIL sat_count255 got=%0d want=255", sat_count); end
    req0_valid = 0;
    advance();
  endtask

  task automatic test_mixed();
    logic [15:0] ta[4] = '{16'h0003, 16'h8005, 16'h0005, 16'h8005};
    logic [15:0] tb[4] = '{16'h8005, 16'h0003, 16'h8005, 16'h0005};
    logic [15:0] tr[4] = '{16'h8002, 16'h8002, 16'h8000, 16'h0000};
    rsp0_ready = 1; req1_valid = 0; req0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req0_a = ta[i]; req0_b = tb[i];
      advance();
      total++; if (rsp_data !== tr[i] || rsp_sat !== 1'b0 || rsp0_valid !== 1'b1) begin bad++; $display("FAIL mixed%0d got=%h/%b want=%h/0", i, rsp_data, rsp_sat, tr[i]); end
    end
    req0_valid = 0;
    advance();
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0003; rsp0_ready = 0; rsp1_ready = 1;
    advance();
    req0_valid = 0; req1_valid = 1; req1_a = 16'h0100; req1_b = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL stall_rdy c=%0d got=%b%b want=00", i, req0_ready, req1_ready); end
      total++; if (rsp_data !== 16'h0008 || rsp0_valid !== 1'b1) begin bad++; $display("FAIL stall_hold c=%0d got=%h/%b want=0008/1", i, rsp_data, rsp0_valid); end
      advance();
    end
    rsp0_ready = 1;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b want=1", req1_ready); end
    advance();
    req1_valid = 0; rsp1_ready = 0;
    #1;
    total++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== 16'h0120) begin bad++; $display("FAIL stall_next got=%b%b/%h want=01/0120", rsp0_valid, rsp1_valid, rsp_data); end
    rst = 1;
    #1;
    total++; if (rsp1_valid !== 1'b0 || rsp_data !== 16'h0000) begin bad++; $display("FAIL midrst got=%b/%h want=0/0000", rsp1_valid, rsp_data); end
    reset_model();
    @(posedge clk); #1;
    rst = 0;
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0); req1_valid = ($urandom_range(0, 3) != 0);
      rsp0_ready = ($urandom_range(0, 2) != 0); rsp1_ready = ($urandom_range(0, 2) != 0);
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      #1;
      predict();
      total++; if (req0_ready !== e_rdy0 || req1_ready !== e_rdy1) begin bad++; $display("FAIL rnd_rdy i=%0d got=%b%b want=%b%b", i, req0_ready, req1_ready, e_rdy0, e_rdy1); end
      advance();
      total++; if (rsp0_valid !== (m_full && !m_owner) || rsp1_valid !== (m_full && m_owner)) begin bad++; $display("FAIL rnd_rspv i=%0d got=%b%b want=%b%b", i, rsp0_valid, rsp1_valid, m_full && !m_owner, m_full && m_owner); end
      total++; if (rsp_data !== m_data || rsp_sat !== m_sat || sat_count !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_data i=%0d got=%h/%b/%0d want=%h/%b/%0d", i, rsp_data, rsp_sat, sat_count, m_data, m_sat, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_mixed();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
